// File: rtl/hv_fire_seq_if.sv
// hv_fire_seq_if: pad/ADC inputs and HV drive outputs of the firing sequencer.
// master = pad/ADC front end side, slave = the sequencer itself.
interface hv_fire_seq_if;
   logic        arm_button;
   logic        fire_button;
   logic        lt3420_done;
   logic        cont;
   logic [2:0]  iset;
   logic [11:0] ad_i;
   logic        ad_strobe;
   logic        lt3420_charge;
   logic        pwm;
   logic        dump;
   logic        arm_led;
   logic        cont_led;
   logic        speaker;
   logic        fault;
   logic [2:0]  state;

   modport master (
      output arm_button, fire_button, lt3420_done, cont, iset, ad_i, ad_strobe,
      input  lt3420_charge, pwm, dump, arm_led, cont_led, speaker, fault, state
   );

   modport slave (
      input  arm_button, fire_button, lt3420_done, cont, iset, ad_i, ad_strobe,
      output lt3420_charge, pwm, dump, arm_led, cont_led, speaker, fault, state
   );
endinterface

// File: rtl/hv_fire_seq.sv
// hv_fire_seq: safety sequencer for the HV firing path (LT3420 charger, PWM
// pass switch, dump resistor, continuity sense).
// Optional feature macro: CONT_TONE_EN (continuity tone on speaker).
// Outputs are decoded from the next state and registered, so they line up
// with the state output and the pwm/charge/dump invariants hold every cycle.
module hv_fire_seq #(
   parameter int unsigned DEBOUNCE_CYC   = 48000,
   parameter int unsigned CHARGE_TMO_CYC = 240000000,
   parameter int unsigned FIRE_CYC       = 480000,
   parameter int unsigned DUMP_CYC       = 4800000,
   parameter int unsigned PWM_PERIOD     = 1024,
   parameter int unsigned AMP_LSB        = 136
) (
   input  logic          clk,
   input  logic          reset,
   hv_fire_seq_if.slave  bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CHARGE = 3'd1;
   localparam logic [2:0] S_ARMED  = 3'd2;
   localparam logic [2:0] S_FIRE   = 3'd3;
   localparam logic [2:0] S_DUMP   = 3'd4;
   localparam logic [2:0] S_FAULT  = 3'd5;

   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int PW = (PWM_PERIOD > 2) ? $clog2(PWM_PERIOD) : 1;
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYC - 1);
   localparam logic [PW-1:0] PWM_LAST  = PW'(PWM_PERIOD - 1);
   localparam logic [PW-1:0] PWM_HALF  = PW'(PWM_PERIOD / 2);
   localparam logic [31:0]   CHG_LAST  = 32'(CHARGE_TMO_CYC - 1);
   localparam logic [31:0]   FIRE_LAST = 32'(FIRE_CYC - 1);
   localparam logic [31:0]   DUMP_LAST = 32'(DUMP_CYC - 1);

   // synchronisers: bit 0 arm, 1 fire, 2 charger done, 3 continuity
   logic [3:0]          sync1_q, sync1_d, sync2_q, sync2_d;
   logic [1:0]          db_q, db_d;
   logic [1:0][CW-1:0]  db_cnt_q, db_cnt_d;
   logic                fire_prev_q, fire_prev_d;
   logic [2:0]          state_q, state_d;
   logic [31:0]         tmr_q, tmr_d;
   logic [23:0]         free_q, free_d;
   logic [11:0]         target_q, target_d;
   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic                pwm_q, pwm_d;
   logic                charge_q, charge_d;
   logic                dump_q, dump_d;
   logic                arm_led_q, arm_led_d;
   logic                cont_led_q, cont_led_d;
   logic                fault_q, fault_d;

   logic arm_db, fire_rise, done_s, cont_s, fire_entry, cut;

   assign arm_db    = db_q[0];
   assign fire_rise = db_q[1] & ~fire_prev_q;
   assign done_s    = sync2_q[2];
   assign cont_s    = sync2_q[3];

   // input sync, per-button debounce and the free-running blink/tone counter
   always_comb begin
      sync1_d     = {bus.cont, bus.lt3420_done, bus.fire_button, bus.arm_button};
      sync2_d     = sync1_q;
      db_d        = db_q;
      db_cnt_d    = db_cnt_q;
      fire_prev_d = db_q[1];
      free_d      = free_q + 1'b1;
      for (int b = 0; b < 2; b++) begin
         if (sync2_q[b] == db_q[b]) begin
            db_cnt_d[b] = '0;
         end else if (db_cnt_q[b] == DB_LAST) begin
            db_cnt_d[b] = '0;
            db_d[b]     = sync2_q[b];
         end else begin
            db_cnt_d[b] = db_cnt_q[b] + 1'b1;
         end
      end
   end

   // safety state machine; one timer serves charge timeout, fire window and dump hold
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (arm_db && cont_s) state_d = S_CHARGE;
         S_CHARGE: begin
            if (!arm_db)                state_d = S_DUMP;
            else if (done_s)            state_d = S_ARMED;
            else if (tmr_q == CHG_LAST) state_d = S_FAULT;
         end
         // disarm beats a simultaneous fire press
         S_ARMED: begin
            if (!arm_db || !cont_s) state_d = S_DUMP;
            else if (fire_rise)     state_d = S_FIRE;
         end
         // continuity loss is ignored here: the igniter is expected to burn open
         S_FIRE:   if (!arm_db || tmr_q == FIRE_LAST) state_d = S_DUMP;
         S_DUMP:   if (!arm_db && tmr_q >= DUMP_LAST) state_d = S_IDLE;
         S_FAULT:  if (!arm_db) state_d = S_IDLE;
         default:  state_d = S_FAULT;
      endcase

      if (state_d != state_q) tmr_d = '0;
      else if (tmr_q != '1)   tmr_d = tmr_q + 1'b1;
      else                    tmr_d = tmr_q;
   end

   // fire-window PWM: set at period start, cut on first strobe at/above target or at half period
   always_comb begin
      fire_entry = (state_d == S_FIRE) && (state_q != S_FIRE);
      target_d   = fire_entry ? 12'(32'(bus.iset) * AMP_LSB) : target_q;
      cut        = bus.ad_strobe && (bus.ad_i >= target_q);
      if (state_d != S_FIRE || fire_entry) pcnt_d = '0;
      else if (pcnt_q == PWM_LAST)         pcnt_d = '0;
      else                                 pcnt_d = pcnt_q + 1'b1;
      pwm_d = 1'b0;
      if (state_d == S_FIRE && target_d != '0) begin
         if (pcnt_d == '0)                               pwm_d = 1'b1;
         else if (pwm_q && pcnt_d != PWM_HALF && !cut)   pwm_d = 1'b1;
      end
   end

   // output decode from the next state so registered outputs track state_q
   always_comb begin
      charge_d   = (state_d == S_CHARGE) || (state_d == S_ARMED);
      dump_d     = (state_d == S_IDLE) || (state_d == S_DUMP) || (state_d == S_FAULT);
      arm_led_d  = (state_d == S_ARMED) || ((state_d == S_CHARGE) && free_q[23]);
      cont_led_d = cont_s;
      if (state_d == S_FAULT)                               fault_d = 1'b1;
      else if (state_d == S_CHARGE && state_q != S_CHARGE)  fault_d = 1'b0;
      else                                                  fault_d = fault_q;
   end

   // all state; reset forces the safe condition (dump on, everything else off) immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_q        <= '0;
         db_cnt_q    <= '0;
         fire_prev_q <= 1'b0;
         state_q     <= S_IDLE;
         tmr_q       <= '0;
         free_q      <= '0;
         target_q    <= '0;
         pcnt_q      <= '0;
         pwm_q       <= 1'b0;
         charge_q    <= 1'b0;
         dump_q      <= 1'b1;
         arm_led_q   <= 1'b0;
         cont_led_q  <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         db_q        <= db_d;
         db_cnt_q    <= db_cnt_d;
         fire_prev_q <= fire_prev_d;
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         free_q      <= free_d;
         target_q    <= target_d;
         pcnt_q      <= pcnt_d;
         pwm_q       <= pwm_d;
         charge_q    <= charge_d;
         dump_q      <= dump_d;
         arm_led_q   <= arm_led_d;
         cont_led_q  <= cont_led_d;
         fault_q     <= fault_d;
      end
   end

`ifdef CONT_TONE_EN
   logic speaker_q, speaker_d;

   // ~1.5 kHz tone with continuity in IDLE, chirped by bit 22 in ARMED
   always_comb begin
      speaker_d = cont_s && free_q[14] &&
                  ((state_d == S_IDLE) || ((state_d == S_ARMED) && free_q[22]));
   end

   // tone register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) speaker_q <= 1'b0;
      else       speaker_q <= speaker_d;
   end

   assign bus.speaker = speaker_q;
`else
   assign bus.speaker = 1'b0;
`endif

   assign bus.state         = state_q;
   assign bus.pwm           = pwm_q;
   assign bus.lt3420_charge = charge_q;
   assign bus.dump          = dump_q;
   assign bus.arm_led       = arm_led_q;
   assign bus.cont_led      = cont_led_q;
   assign bus.fault         = fault_q;

endmodule

// File: tb/tb_hv_fire_seq.sv
// tb_hv_fire_seq: directed scenarios for hv_fire_seq with small timing parameters.
module tb_hv_fire_seq;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int passes = 0;

   hv_fire_seq_if bus();

   hv_fire_seq #(
      .DEBOUNCE_CYC(4), .CHARGE_TMO_CYC(200), .FIRE_CYC(100),
      .DUMP_CYC(20), .PWM_PERIOD(16), .AMP_LSB(136)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic settle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (bus.state == s) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic idle_inputs();
      bus.arm_button = 0; bus.fire_button = 0; bus.lt3420_done = 0; bus.cont = 0;
      bus.iset = 0; bus.ad_i = 0; bus.ad_strobe = 0;
   endtask

   task automatic test_reset();
      logic [9:0] got;
      idle_inputs();
      reset = 1'b1;
      settle(3);
      got = {bus.state, bus.dump, bus.lt3420_charge, bus.pwm, bus.arm_led, bus.cont_led, bus.speaker, bus.fault};
      checks++; if (got !== 10'b000_1_000000) $display("FAIL reset_outputs: got %b want %b", got, 10'b000_1_000000); else passes++;
      reset = 1'b0;
      settle(6);
      checks++; if ({bus.state, bus.dump} !== {3'd0, 1'b1}) $display("FAIL reset_idle: got state %0d dump %b want 0 1", bus.state, bus.dump); else passes++;
   endtask

   task automatic test_normal_shot();
      bit ok, stay;
      int errs;
      bus.iset = 3'd2; bus.cont = 1; bus.arm_button = 1;
      wait_state(3'd1, 20, ok);
      checks++; if (!ok) $display("FAIL shot_enter_charge: state %0d want 1", bus.state); else passes++;
      checks++; if ({bus.lt3420_charge, bus.dump} !== 2'b10) $display("FAIL shot_charge_out: got %b want 10", {bus.lt3420_charge, bus.dump}); else passes++;
      stay = 1;
      repeat (50) begin @(negedge clk); if (bus.state != 3'd1) stay = 0; end
      checks++; if (!stay) $display("FAIL shot_charge_hold: left CHARGE early, state %0d want 1", bus.state); else passes++;
      bus.lt3420_done = 1;
      wait_state(3'd2, 10, ok);
      checks++; if (!ok) $display("FAIL shot_enter_armed: state %0d want 2", bus.state); else passes++;
      checks++; if ({bus.arm_led, bus.lt3420_charge, bus.dump} !== 3'b110) $display("FAIL shot_armed_out: got %b want 110", {bus.arm_led, bus.lt3420_charge, bus.dump}); else passes++;
      bus.fire_button = 1;
      wait_state(3'd3, 15, ok);
      checks++; if (!ok) $display("FAIL shot_enter_fire: state %0d want 3", bus.state); else passes++;
      // target 272: strobe 100 at count 1 must not cut, strobe 300 at count 3 cuts -> high for counts 0..3
      errs = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus.pwm !== ((k % 16) < 4)) errs++;
         if (bus.state != 3'd3) errs++;
         if (bus.pwm && (bus.lt3420_charge || bus.dump)) errs++;
         bus.ad_strobe = ((k % 16) == 1) || ((k % 16) == 3);
         bus.ad_i = ((k % 16) == 3) ? 12'd300 : 12'd100;
         @(negedge clk);
      end
      bus.ad_strobe = 0;
      checks++; if (errs != 0) $display("FAIL shot_pwm_window: %0d bad cycles want 0", errs); else passes++;
      checks++; if ({bus.state, bus.pwm, bus.dump} !== {3'd4, 1'b0, 1'b1}) $display("FAIL shot_enter_dump: got state %0d pwm %b dump %b want 4 0 1", bus.state, bus.pwm, bus.dump); else passes++;
      stay = 1;
      repeat (30) begin @(negedge clk); if (bus.state != 3'd4) stay = 0; end
      checks++; if (!stay) $display("FAIL shot_no_rearm: state %0d want 4 while arm held", bus.state); else passes++;
      bus.arm_button = 0; bus.fire_button = 0; bus.lt3420_done = 0;
      wait_state(3'd0, 15, ok);
      checks++; if (!ok) $display("FAIL shot_back_idle: state %0d want 0", bus.state); else passes++;
      settle(10);
   endtask

   task automatic test_charge_timeout();
      bit ok;
      int n;
      bus.cont = 1; bus.lt3420_done = 0; bus.arm_button = 1;
      wait_state(3'd1, 20, ok);
      n = 0;
      while (bus.state == 3'd1 && n < 300) begin n++; @(negedge clk); end
      checks++; if (n != 200) $display("FAIL tmo_cycles: got %0d want 200", n); else passes++;
      checks++; if ({bus.state, bus.fault, bus.dump, bus.lt3420_charge} !== {3'd5, 1'b1, 1'b1, 1'b0}) $display("FAIL tmo_fault_out: got state %0d fault %b dump %b chg %b want 5 1 1 0", bus.state, bus.fault, bus.dump, bus.lt3420_charge); else passes++;
      bus.arm_button = 0;
      wait_state(3'd0, 15, ok);
      checks++; if (!ok || bus.fault !== 1'b1) $display("FAIL tmo_idle_sticky: state %0d fault %b want 0 1", bus.state, bus.fault); else passes++;
      bus.arm_button = 1;
      wait_state(3'd1, 15, ok);
      checks++; if (!ok || bus.fault !== 1'b0) $display("FAIL tmo_rearm_clear: state %0d fault %b want 1 0", bus.state, bus.fault); else passes++;
      bus.arm_button = 0;
      wait_state(3'd0, 40, ok);
      checks++; if (!ok) $display("FAIL tmo_disarm_idle: state %0d want 0", bus.state); else passes++;
      settle(10);
   endtask

   task automatic test_arm_release_fire();
      bit ok, saw_pwm, saw_fire;
      bus.iset = 3'd5; bus.cont = 1; bus.lt3420_done = 1; bus.arm_button = 1;
      wait_state(3'd2, 20, ok);
      checks++; if (!ok) $display("FAIL race_armed: state %0d want 2", bus.state); else passes++;
      bus.arm_button = 0; bus.fire_button = 1;
      saw_pwm = 0; saw_fire = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.pwm) saw_pwm = 1;
         if (bus.state == 3'd3) saw_fire = 1;
      end
      checks++; if (saw_pwm || saw_fire) $display("FAIL race_no_fire: pwm seen %b fire seen %b want 0 0", saw_pwm, saw_fire); else passes++;
      checks++; if (bus.state !== 3'd4) $display("FAIL race_dump: state %0d want 4", bus.state); else passes++;
      bus.fire_button = 0; bus.lt3420_done = 0;
      wait_state(3'd0, 40, ok);
      settle(10);
   endtask

   task automatic test_iset_zero();
      bit ok;
      int n, hi;
      bus.iset = 3'd0; bus.cont = 1; bus.lt3420_done = 1; bus.arm_button = 1;
      wait_state(3'd2, 20, ok);
      bus.fire_button = 1;
      wait_state(3'd3, 15, ok);
      checks++; if (!ok) $display("FAIL zero_enter_fire: state %0d want 3", bus.state); else passes++;
      bus.ad_strobe = 1; bus.ad_i = 12'd0;
      n = 0; hi = 0;
      while (bus.state == 3'd3 && n < 150) begin
         n++;
         if (bus.pwm) hi++;
         @(negedge clk);
      end
      bus.ad_strobe = 0;
      checks++; if (hi != 0) $display("FAIL zero_pwm: got %0d high cycles want 0", hi); else passes++;
      checks++; if (n != 100) $display("FAIL zero_window: got %0d cycles want 100", n); else passes++;
      checks++; if (bus.state !== 3'd4) $display("FAIL zero_dump: state %0d want 4", bus.state); else passes++;
      bus.arm_button = 0; bus.fire_button = 0; bus.lt3420_done = 0;
      wait_state(3'd0, 40, ok);
      settle(10);
   endtask

   task automatic test_no_current();
      bit ok, stay;
      int errs;
      bus.iset = 3'd7; bus.cont = 1; bus.lt3420_done = 1; bus.arm_button = 1;
      wait_state(3'd2, 20, ok);
      // bounce: 2 high, 3 low, 3 high, then low -- never 4 stable high samples
      stay = 1;
      for (int i = 0; i < 30; i++) begin
         bus.fire_button = (i < 2) || (i >= 5 && i < 8);
         @(negedge clk);
         if (bus.state != 3'd2) stay = 0;
      end
      checks++; if (!stay) $display("FAIL bounce_no_fire: state %0d want 2", bus.state); else passes++;
      bus.fire_button = 1;
      wait_state(3'd3, 15, ok);
      checks++; if (!ok) $display("FAIL nocur_enter_fire: state %0d want 3", bus.state); else passes++;
      bus.ad_strobe = 1; bus.ad_i = 12'd0;
      errs = 0;
      for (int k = 0; k < 100; k++) begin
         if (bus.pwm !== ((k % 16) < 8)) errs++;
         if (bus.pwm && (bus.lt3420_charge || bus.dump)) errs++;
         @(negedge clk);
      end
      bus.ad_strobe = 0;
      checks++; if (errs != 0) $display("FAIL nocur_half_duty: %0d bad cycles want 0", errs); else passes++;
      checks++; if ({bus.state, bus.pwm} !== {3'd4, 1'b0}) $display("FAIL nocur_dump: state %0d pwm %b want 4 0", bus.state, bus.pwm); else passes++;
      bus.arm_button = 0; bus.fire_button = 0; bus.lt3420_done = 0;
      wait_state(3'd0, 40, ok);
      settle(10);
   endtask

   task automatic test_async_reset();
      bit ok;
      bus.iset = 3'd7; bus.cont = 1; bus.lt3420_done = 1; bus.arm_button = 1;
      bus.ad_strobe = 1; bus.ad_i = 12'd0;
      wait_state(3'd2, 20, ok);
      bus.fire_button = 1;
      wait_state(3'd3, 15, ok);
      settle(16);
      checks++; if (bus.pwm !== 1'b1) $display("FAIL arst_pre_pwm: got %b want 1", bus.pwm); else passes++;
      #2 reset = 1'b1;
      #1;
      checks++; if ({bus.pwm, bus.dump, bus.state} !== {1'b0, 1'b1, 3'd0}) $display("FAIL arst_immediate: pwm %b dump %b state %0d want 0 1 0", bus.pwm, bus.dump, bus.state); else passes++;
      @(negedge clk);
      idle_inputs();
      settle(2);
      reset = 1'b0;
      settle(10);
   endtask

   task automatic test_tone();
      bit prev;
      int n, hi;
      bus.cont = 1;
      settle(10);
`ifdef CONT_TONE_EN
      prev = bus.speaker; n = 0;
      while (bus.speaker == prev && n < 20000) begin @(negedge clk); n++; end
      prev = bus.speaker; n = 0;
      while (bus.speaker == prev && n < 20000) begin @(negedge clk); n++; end
      checks++; if (n != 16384) $display("FAIL tone_half_period: got %0d want 16384", n); else passes++;
`else
      hi = 0;
      repeat (200) begin @(negedge clk); if (bus.speaker) hi++; end
      checks++; if (hi != 0) $display("FAIL tone_off: got %0d high cycles want 0", hi); else passes++;
`endif
      bus.cont = 0;
   endtask

   initial begin
      test_reset();
      test_normal_shot();
      test_charge_timeout();
      test_arm_release_fire();
      test_iset_zero();
      test_no_current();
      test_async_reset();
      test_tone();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
